// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------------+
// | hazard_pkg : shared types, default latencies and class->latency helper       |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam int LAT_ALU_DEF  = 2;
  localparam int LAT_LOAD_DEF = 3;
  localparam int LAT_FPU_DEF  = 4;
  localparam int LAT_FDIV_DEF = 12;

  typedef enum logic [2:0] {
    HZ_NONE = 3'd0,
    HZ_ALU  = 3'd1,
    HZ_LOAD = 3'd2,
    HZ_FPU  = 3'd3,
    HZ_FDIV = 3'd4
  } hz_class_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_DATA   = 2'd1,
    CAUSE_STRUCT = 2'd2,
    CAUSE_EXT    = 2'd3
  } hz_cause_t;

  function automatic int lat_of(input hz_class_t c,
                                input int la = LAT_ALU_DEF,
                                input int ll = LAT_LOAD_DEF,
                                input int lf = LAT_FPU_DEF,
                                input int ld = LAT_FDIV_DEF);
    int l;
    case (c)
      HZ_ALU:  l = la;
      HZ_LOAD: l = ll;
      HZ_FPU:  l = lf;
      HZ_FDIV: l = ld;
      default: l = 0;
    endcase
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctl_sb_bank.sv
// +----------------------------------------------------------------------------+
// | sb_bank : 32-entry pending-write scoreboard (countdown + ALU flag per entry) |
// | Optional feature macro: FWD_ALU_EN (ALU result one cycle old reads ready)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sb_bank #(
  parameter int CW      = 4,
  parameter int LAT_ALU = 2,
  parameter bit MASK_X0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tick,
  input  logic          i_set,
  input  logic [4:0]    i_set_idx,
  input  logic [CW-1:0] i_set_cnt,
  input  logic          i_set_alu,
  output logic [CW-1:0] o_set_cnt,
  input  logic [4:0]    i_ra_idx,
  output logic          o_ra_rdy,
  input  logic [4:0]    i_rb_idx,
  output logic          o_rb_rdy
);

`ifdef FWD_ALU_EN
  localparam bit c_fwd_alu = 1'b1;
`else
  localparam bit c_fwd_alu = 1'b0;
`endif

  logic [CW-1:0] w_cnt [32];
  logic          w_alu [32];

  for (genvar k = 0; k < 32; k++) begin : g_entry
    if (MASK_X0 && k == 0) begin : g_zero
      assign w_cnt[k] = '0;
      assign w_alu[k] = 1'b0;
    end else begin : g_live
      logic [CW-1:0] r_cnt;
      logic          r_alu;

      // A new producer overrides the countdown in the same cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_alu <= 1'b0;
        end else if (i_tick) begin
          if (i_set && i_set_idx == 5'(k)) begin
            r_cnt <= i_set_cnt;
            r_alu <= i_set_alu;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      end

      assign w_cnt[k] = r_cnt;
      assign w_alu[k] = r_alu;
    end
  end

  assign o_set_cnt = w_cnt[i_set_idx];
  assign o_ra_rdy  = (w_cnt[i_ra_idx] == '0) |
                     (c_fwd_alu & w_alu[i_ra_idx] & (w_cnt[i_ra_idx] == CW'(LAT_ALU)));
  assign o_rb_rdy  = (w_cnt[i_rb_idx] == '0) |
                     (c_fwd_alu & w_alu[i_rb_idx] & (w_cnt[i_rb_idx] == CW'(LAT_ALU)));

endmodule

`default_nettype wire

// File: rtl/hazard_ctl.sv
// +----------------------------------------------------------------------------+
// | hazard_ctl : decode-stage issue scheduler (RAW/WAW, writeback port, FDIV)    |
// | Optional feature macro: FWD_ALU_EN (handled inside sb_bank)                 |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int LAT_ALU  = LAT_ALU_DEF,
  parameter int LAT_LOAD = LAT_LOAD_DEF,
  parameter int LAT_FPU  = LAT_FPU_DEF,
  parameter int LAT_FDIV = LAT_FDIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  hz_class_t  id_class,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_f,
  input  logic       id_use_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_f,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rwe,
  input  logic       id_fwe,
  input  logic       ext_stall,
  output logic       n_stall,
  output logic       issue,
  output hz_cause_t  stall_why,
  output logic       fdiv_busy
);

  localparam int c_cw = $clog2(LAT_FDIV + 1);

  logic [c_cw-1:0]     w_lat, w_lat_p1, w_i_rd_cnt, w_f_rd_cnt;
  logic                w_adv, w_prod, w_wb_set;
  logic                w_i_rdy_a, w_i_rdy_b, w_f_rdy_a, w_f_rdy_b;
  logic                w_rdy1, w_rdy2, w_raw, w_waw, w_data, w_struct;
  logic [LAT_FDIV:1]   r_rsv, w_rsv_nxt;
  logic [LAT_FDIV+1:1] w_rsv_ext;
  logic [c_cw-1:0]     r_fdiv_cnt;

  assign w_adv    = ~ext_stall;
  assign w_lat    = c_cw'(lat_of(id_class, LAT_ALU, LAT_LOAD, LAT_FPU, LAT_FDIV));
  assign w_lat_p1 = w_lat + c_cw'(1);
  assign w_prod   = (id_rwe | id_fwe) & (id_class != HZ_NONE);
  assign w_wb_set = issue & w_prod;

  sb_bank #(.CW(c_cw), .LAT_ALU(LAT_ALU), .MASK_X0(1'b1)) u_int_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_adv),
    .i_set     (w_wb_set & id_rwe),
    .i_set_idx (id_rd),
    .i_set_cnt (w_lat),
    .i_set_alu (id_class == HZ_ALU),
    .o_set_cnt (w_i_rd_cnt),
    .i_ra_idx  (id_rs1),
    .o_ra_rdy  (w_i_rdy_a),
    .i_rb_idx  (id_rs2),
    .o_rb_rdy  (w_i_rdy_b)
  );

  sb_bank #(.CW(c_cw), .LAT_ALU(LAT_ALU), .MASK_X0(1'b0)) u_flt_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_adv),
    .i_set     (w_wb_set & id_fwe),
    .i_set_idx (id_rd),
    .i_set_cnt (w_lat),
    .i_set_alu (id_class == HZ_ALU),
    .o_set_cnt (w_f_rd_cnt),
    .i_ra_idx  (id_rs1),
    .o_ra_rdy  (w_f_rdy_a),
    .i_rb_idx  (id_rs2),
    .o_rb_rdy  (w_f_rdy_b)
  );

  assign w_rdy1 = id_rs1_f ? w_f_rdy_a : w_i_rdy_a;
  assign w_rdy2 = id_rs2_f ? w_f_rdy_b : w_i_rdy_b;
  assign w_raw  = (id_use_rs1 & ~w_rdy1) | (id_use_rs2 & ~w_rdy2);
  assign w_waw  = w_prod & ((id_rwe & (w_i_rd_cnt > w_lat)) |
                            (id_fwe & (w_f_rd_cnt > w_lat)));
  assign w_data = w_raw | w_waw;

  // Top slot is a constant 0 so the longest class never sees a conflict beyond the window.
  assign w_rsv_ext = {1'b0, r_rsv};
  assign fdiv_busy = (r_fdiv_cnt != '0);
  assign w_struct  = (w_prod & w_rsv_ext[w_lat_p1]) | ((id_class == HZ_FDIV) & fdiv_busy);

  assign n_stall = ~ext_stall & ~(id_valid & (w_data | w_struct));
  assign issue   = id_valid & n_stall;

  always_comb begin
    stall_why = CAUSE_NONE;
    if (ext_stall)
      stall_why = CAUSE_EXT;
    else if (id_valid & w_data)
      stall_why = CAUSE_DATA;
    else if (id_valid & w_struct)
      stall_why = CAUSE_STRUCT;
  end

  always_comb begin
    w_rsv_nxt = '0;
    for (int i = 1; i <= LAT_FDIV; i++) begin
      w_rsv_nxt[i] = w_rsv_ext[i+1] | (w_wb_set & (w_lat == c_cw'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsv      <= '0;
      r_fdiv_cnt <= '0;
    end else if (w_adv) begin
      r_rsv <= w_rsv_nxt;
      if (issue && id_class == HZ_FDIV)
        r_fdiv_cnt <= c_cw'(LAT_FDIV);
      else if (r_fdiv_cnt != '0)
        r_fdiv_cnt <= r_fdiv_cnt - c_cw'(1);
    end
  end

endmodule

`default_nettype wire
